// File: rtl/con1_eval_arbiter.sv
// Round-robin arbiter that time-shares one external con1 evaluation core between N_REQ requesters.
// One request is in flight at a time: grant, wait CORE_LAT cycles, then return {f1,f0} to the owner.
module con1_eval_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CORE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [7*N_REQ-1:0]   req_vec,
  output logic [N_REQ-1:0]     req_ready,
  output logic [6:0]           core_in,
  input  logic [1:0]           core_out,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [1:0]           rsp_f,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] OneHot0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [6:0]        core_in_q, core_in_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_f_q, rsp_f_d;

  logic              gnt_found;
  logic [PtrW-1:0]   gnt_idx;
  logic [6:0]        gnt_vec;
  int unsigned       scan_idx;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PtrW'(scan_idx);
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_found && (gnt_idx == PtrW'(k))) begin
        gnt_vec = req_vec[7*k +: 7];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    core_in_d   = core_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_f_d     = rsp_f_q;
    req_ready   = '0;

    case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready = OneHot0 << gnt_idx;
          core_in_d = gnt_vec;
          owner_d   = gnt_idx;
          lat_cnt_d = 4'(CORE_LAT - 1);
          rr_ptr_d  = (gnt_idx == PtrW'(N_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (lat_cnt_q == 4'd0) begin
          rsp_f_d     = core_out;
          rsp_valid_d = OneHot0 << owner_q;
          state_d     = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lat_cnt_q   <= '0;
      core_in_q   <= '0;
      rsp_valid_q <= '0;
      rsp_f_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      core_in_q   <= core_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_f_q     <= rsp_f_d;
    end
  end

  assign core_in   = core_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_con1_eval_arbiter.sv
// Directed bench for con1_eval_arbiter: one CORE_LAT=1 instance with a combinational core model,
// one CORE_LAT=4 instance whose core model settles two cycles after core_in changes.
module tb_con1_eval_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req_valid = '0;
  logic [27:0] req_vec   = '0;
  logic [3:0]  req_ready;
  logic [6:0]  core_in;
  logic [1:0]  core_out;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_f;
  logic        rsp_ready = 1'b1;
  logic        busy;

  logic [3:0]  req_valid2 = '0;
  logic [27:0] req_vec2   = '0;
  logic [3:0]  req_ready2;
  logic [6:0]  core_in2;
  logic [1:0]  core_out2;
  logic [3:0]  rsp_valid2;
  logic [1:0]  rsp_f2;
  logic        rsp_ready2 = 1'b1;
  logic        busy2;

  logic [6:0]  dly1, dly2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // Core model at the directed points; other vectors get an arbitrary but fixed mapping.
  function automatic logic [1:0] con1_ref(input logic [6:0] v);
    case (v)
      7'h00:   con1_ref = 2'b10;
      7'h03:   con1_ref = 2'b11;
      7'h21:   con1_ref = 2'b00;
      7'h3D:   con1_ref = 2'b01;
      7'h31:   con1_ref = 2'b10;
      default: con1_ref = v[1:0] ^ v[6:5];
    endcase
  endfunction

  assign core_out = con1_ref(core_in);

  always @(posedge clk) begin
    dly1 <= core_in2;
    dly2 <= dly1;
  end
  assign core_out2 = con1_ref(dly2);

  con1_eval_arbiter #(.N_REQ(4), .CORE_LAT(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_vec   (req_vec),
    .req_ready (req_ready),
    .core_in   (core_in),
    .core_out  (core_out),
    .rsp_valid (rsp_valid),
    .rsp_f     (rsp_f),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  con1_eval_arbiter #(.N_REQ(4), .CORE_LAT(4)) u_dut_lat4 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid2),
    .req_vec   (req_vec2),
    .req_ready (req_ready2),
    .core_in   (core_in2),
    .core_out  (core_out2),
    .rsp_valid (rsp_valid2),
    .rsp_f     (rsp_f2),
    .rsp_ready (rsp_ready2),
    .busy      (busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a negedge with the DUT idle and rsp_ready=1.
  task automatic serve(input int idx, input logic [6:0] vec, input logic [1:0] expf,
                       input string tag);
    int n;
    req_vec[7*idx +: 7] = vec;
    req_valid = 4'b0001 << idx;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << idx));
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (rsp_valid == 4'b0000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({tag, "_timeout"}, 32'(n < 10), 32'd1);
    check({tag, "_owner"}, 32'(rsp_valid), 32'(4'b0001 << idx));
    check({tag, "_f"}, 32'(rsp_f), 32'(expf));
    @(negedge clk);
  endtask

  initial begin
    int ng, last, n, first;
    logic [1:0] f_first;
    logic [3:0] own_first;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_f", 32'(rsp_f), 32'h0);
    check("rst_core_in", 32'(core_in), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single request, all-zero vector
    req_valid = 4'b0001;
    req_vec   = '0;
    #1;
    check("t1_ready_c0", 32'(req_ready), 32'h1);
    check("t1_busy_c0", 32'(busy), 32'h0);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t1_busy_c1", 32'(busy), 32'h1);
    check("t1_rsp_c1", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    check("t1_rsp_c2", 32'(rsp_valid), 32'h1);
    check("t1_f_c2", 32'(rsp_f), 32'h2);
    check("t1_busy_c2", 32'(busy), 32'h1);
    @(negedge clk);
    #1;
    check("t1_busy_c3", 32'(busy), 32'h0);
    check("t1_rsp_c3", 32'(rsp_valid), 32'h0);

    // Truth points through requester 2
    serve(2, 7'h03, 2'b11, "tt03");
    serve(2, 7'h21, 2'b00, "tt21");
    serve(2, 7'h3D, 2'b01, "tt3d");
    serve(2, 7'h31, 2'b10, "tt31");

    // Round robin from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_vec   = {7'h31, 7'h3D, 7'h21, 7'h03};
    req_valid = 4'b1111;
    ng = 0;
    last = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready != 4'b0000 && ng < 6) begin
        check("rr_grant", 32'(req_ready), 32'(4'b0001 << (ng % 4)));
        if (ng > 0) check("rr_gap", 32'(c - last), 32'd3);
        last = c;
        ng++;
      end
      @(negedge clk);
    end
    check("rr_count", 32'(ng), 32'd6);
    req_valid = '0;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rr_drain", 32'(busy), 32'h0);

    // Response backpressure on requester 1
    rsp_ready = 1'b0;
    req_vec[13:7] = 7'h03;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (rsp_valid == 4'b0000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_timeout", 32'(n < 10), 32'd1);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'h2);
      check("bp_rsp_f", 32'(rsp_f), 32'h3);
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_core_in", 32'(core_in), 32'h03);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_idle_busy", 32'(busy), 32'h0);
    check("bp_idle_rsp", 32'(rsp_valid), 32'h0);
    check("bp_next_grant", 32'(req_ready), 32'h4);
    req_valid = '0;
    @(negedge clk);

    // CORE_LAT=4 instance: settled sample, response at acceptance+5
    req_vec2[6:0] = 7'h21;
    req_valid2 = 4'b0001;
    #1;
    check("l4_ready", 32'(req_ready2), 32'h1);
    first = 0;
    f_first = '0;
    own_first = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid2 = '0;
      #1;
      if (rsp_valid2 != 4'b0000 && first == 0) begin
        first = k;
        f_first = rsp_f2;
        own_first = rsp_valid2;
      end
    end
    check("l4_latency", 32'(first), 32'd5);
    check("l4_f", 32'(f_first), 32'h0);
    check("l4_owner", 32'(own_first), 32'h1);

    // Reset one cycle after accept, during WAIT
    @(negedge clk);
    req_vec[20:14] = 7'h3D;
    req_valid = 4'b0100;
    #1;
    check("rw_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("rw_busy_wait", 32'(busy), 32'h1);
    @(negedge clk);
    #1;
    check("rw_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rw_rsp_f", 32'(rsp_f), 32'h0);
    check("rw_core_in", 32'(core_in), 32'h0);
    check("rw_busy", 32'(busy), 32'h0);
    check("rw_ready0", 32'(req_ready), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("rw_no_rsp", 32'(rsp_valid), 32'h0);
    end
    req_valid = 4'b1001;
    #1;
    check("rw_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    #1;
    serve(3, 7'h31, 2'b10, "rw_req3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
